// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake to imem,
// and buffers one fetched instruction for the IF/ID latch.
// Latency: zero-wait imem -> fetch_valid 1 cycle after the request; N wait states add N cycles.
// Backpressure: stall_if holds the buffer and suppresses new requests; an outstanding request still completes.
//
// Ports:
//   clk, rst (async, active-high)
//   stall_if              hazard stall; the buffer is not consumed while high
//   redirect, redirect_pc taken branch/jump from EX; has priority over stall and ack
//   imem_req, imem_addr   fetch request/address (combinational)
//   imem_ack, imem_rdata  memory response; ack may arrive in the request cycle
//   PCOUT, IR             buffered PC/instruction to IF/ID (IR = NOP_INSTR when empty)
//   fetch_valid           buffer holds a real instruction
//   fetch_misalign        only when IF_MISALIGN_CHK_EN is defined: sticky misaligned-redirect flag
//
// Build option: define IF_MISALIGN_CHK_EN to add misaligned-redirect detection.
// Without it, redirect_pc[1:0] is ignored and treated as 2'b00.

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCOUT,
    output logic [31:0] IR,
    output logic        fetch_valid
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] addr_q;
    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_ir;

    logic        consume;
    logic        can_accept;
    logic        fetch_block;
    logic [31:0] redirect_tgt;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign;
    logic redirect_misaligned;

    assign redirect_tgt        = redirect_pc;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // A misaligned target parks the fetcher until the next aligned redirect.
    assign fetch_block         = misalign;
    assign fetch_misalign      = misalign;
`else
    logic unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign fetch_block         = 1'b0;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    assign consume    = buf_valid & ~stall_if;
    assign can_accept = ~buf_valid | consume;

    // Requests from RUN are new fetches; WAIT/DROP keep the accepted request
    // asserted on its captured address until memory acks it.
    always_comb begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (state == ST_RUN) begin
            imem_req  = can_accept & ~redirect & ~fetch_block;
            imem_addr = pc;
        end
    end

    assign PCOUT       = buf_pc;
    assign IR          = buf_ir;
    assign fetch_valid = buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            buf_valid <= 1'b0;
            buf_pc    <= RESET_PC;
            buf_ir    <= NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
            misalign  <= 1'b0;
`endif
        end else if (redirect) begin
            // Redirect wins: flush the buffer and retarget. An unacked request
            // must still be drained, so it finishes in DROP with data discarded.
            pc        <= redirect_tgt;
            buf_valid <= 1'b0;
            buf_ir    <= NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
            misalign  <= redirect_misaligned;
`endif
            case (state)
                ST_RUN: begin
                    if (imem_req && !imem_ack) begin
                        addr_q <= pc;
                        state  <= ST_DROP;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    state <= imem_ack ? ST_RUN : ST_DROP;
                end
                default: state <= ST_RUN;
            endcase
        end else begin
            if (consume) begin
                buf_valid <= 1'b0;
                buf_ir    <= NOP_INSTR;
            end
            // A load below overrides the clear above: consume and ack in the
            // same cycle replace the buffer, sustaining one instruction per cycle.
            case (state)
                ST_RUN: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= pc;
                            buf_ir    <= imem_rdata;
                            pc        <= pc + 32'd4;
                        end else begin
                            addr_q <= pc;
                            state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Buffer is necessarily empty here: the request was only
                    // issued with can_accept and nothing else fills the buffer.
                    if (imem_ack) begin
                        buf_valid <= 1'b1;
                        buf_pc    <= addr_q;
                        buf_ir    <= imem_rdata;
                        pc        <= addr_q + 32'd4;
                        state     <= ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCOUT;
    logic [31:0] IR;
    logic        fetch_valid;
`ifdef IF_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_if   (stall_if),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCOUT      (PCOUT),
        .IR         (IR),
        .fetch_valid(fetch_valid)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction contents used by the scripted table and by the random memory.
    function automatic logic [31:0] td(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    typedef struct {
        logic        stall;
        logic        red;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        efv;
        logic [31:0] epc;
        logic [31:0] eir;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic stall, input logic red, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] rd,
                       input logic ereq, input logic [31:0] eaddr, input logic efv,
                       input logic [31:0] epc, input logic [31:0] eir);
        vec_t v;
        v.stall = stall; v.red = red; v.rpc = rpc; v.ack = ack; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.efv = efv; v.epc = epc; v.eir = eir;
        tab.push_back(v);
    endtask

    // Random-phase memory model and stream scoreboard state.
    logic        m_active;
    int          m_left;
    logic [31:0] m_addr;
    logic [31:0] exp_pc;
    int          ncons;
    logic        prev_red;
    logic        prev_hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_ir;

    initial begin
        rst = 1'b1; stall_if = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //   stall red rpc            ack rdata              req addr           fv pcout          ir
        add(0, 0, 32'h0,          1, td(32'h0),          1, 32'h0,          0, 32'h0,          NOP);
        add(0, 0, 32'h0,          1, td(32'h4),          1, 32'h4,          1, 32'h0,          td(32'h0));
        add(0, 0, 32'h0,          1, td(32'h8),          1, 32'h8,          1, 32'h4,          td(32'h4));
        add(1, 0, 32'h0,          0, JUNK,               0, 32'hC,          1, 32'h8,          td(32'h8));
        add(1, 0, 32'h0,          0, JUNK,               0, 32'hC,          1, 32'h8,          td(32'h8));
        add(1, 0, 32'h0,          0, JUNK,               0, 32'hC,          1, 32'h8,          td(32'h8));
        add(0, 0, 32'h0,          0, JUNK,               1, 32'hC,          1, 32'h8,          td(32'h8));
        add(0, 0, 32'h0,          0, JUNK,               1, 32'hC,          0, 32'h8,          NOP);
        add(0, 0, 32'h0,          1, td(32'hC),          1, 32'hC,          0, 32'h8,          NOP);
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h10,         1, 32'hC,          td(32'hC));
        add(0, 1, 32'h40,         0, JUNK,               1, 32'h10,         0, 32'hC,          NOP);
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h10,         0, 32'hC,          NOP);
        add(0, 0, 32'h0,          1, JUNK,               1, 32'h10,         0, 32'hC,          NOP);
        add(0, 0, 32'h0,          1, td(32'h40),         1, 32'h40,         0, 32'hC,          NOP);
        add(1, 1, 32'h80,         0, JUNK,               0, 32'h44,         1, 32'h40,         td(32'h40));
        add(0, 0, 32'h0,          1, td(32'h80),         1, 32'h80,         0, 32'h40,         NOP);
        add(1, 1, 32'h40,         1, JUNK,               0, 32'h84,         1, 32'h80,         td(32'h80));
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h40,         0, 32'h80,         NOP);
        add(1, 1, 32'h100,        1, JUNK,               1, 32'h40,         0, 32'h80,         NOP);
        add(0, 0, 32'h0,          1, td(32'h100),        1, 32'h100,        0, 32'h80,         NOP);
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h104,        1, 32'h100,        td(32'h100));
        add(0, 1, 32'hFFFF_FFFC,  0, JUNK,               1, 32'h104,        0, 32'h100,        NOP);
        add(0, 0, 32'h0,          1, JUNK,               1, 32'h104,        0, 32'h100,        NOP);
        add(0, 0, 32'h0,          1, td(32'hFFFF_FFFC),  1, 32'hFFFF_FFFC,  0, 32'h100,        NOP);
        add(0, 0, 32'h0,          1, td(32'h0),          1, 32'h0,          1, 32'hFFFF_FFFC,  td(32'hFFFF_FFFC));
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h4,          1, 32'h0,          td(32'h0));
        add(0, 1, 32'h203,        1, JUNK,               1, 32'h4,          0, 32'h0,          NOP);
        add(0, 0, 32'h0,          1, td(32'h200),        1, 32'h200,        0, 32'h0,          NOP);
        add(0, 0, 32'h0,          0, JUNK,               1, 32'h204,        1, 32'h200,        td(32'h200));

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_PCOUT", PCOUT, 32'h0);
        chk("rst_IR", IR, NOP);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Scripted table: release reset and apply one row per cycle.
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            rst         = 1'b0;
            stall_if    = tab[i].stall;
            redirect    = tab[i].red;
            redirect_pc = tab[i].rpc;
            imem_ack    = tab[i].ack;
            imem_rdata  = tab[i].rd;
            #1;
            chk($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, tab[i].ereq});
            chk($sformatf("row%0d_addr", i), imem_addr, tab[i].eaddr);
            chk($sformatf("row%0d_fv", i), {31'b0, fetch_valid}, {31'b0, tab[i].efv});
            chk($sformatf("row%0d_pcout", i), PCOUT, tab[i].epc);
            chk($sformatf("row%0d_ir", i), IR, tab[i].eir);
        end

        // Reset in the middle of a waited fetch: outputs return asynchronously.
        @(negedge clk);
        stall_if = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        chk("arst_PCOUT", PCOUT, 32'h0);
        chk("arst_IR", IR, NOP);
        chk("arst_imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0001;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("post_rst_fv", {31'b0, fetch_valid}, 32'd1);
        chk("post_rst_PCOUT", PCOUT, 32'h0);
        chk("post_rst_IR", IR, 32'h0BAD_0001);

        // Randomized run against a stream-level model: the instructions handed to
        // IF/ID must be consecutive words, restarting at each redirect target.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_active = 1'b0; m_left = 0; m_addr = '0;
        exp_pc = 32'h0; ncons = 0; prev_red = 1'b0; prev_hold = 1'b0;
        hold_pc = '0; hold_ir = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (prev_red) begin
                chk("rnd_redirect_fv", {31'b0, fetch_valid}, 32'd0);
                chk("rnd_redirect_ir", IR, NOP);
            end
            if (prev_hold) begin
                chk("rnd_stall_fv", {31'b0, fetch_valid}, 32'd1);
                chk("rnd_stall_pcout", PCOUT, hold_pc);
                chk("rnd_stall_ir", IR, hold_ir);
            end
            stall_if    = ($urandom % 100) < 30;
            redirect    = ($urandom % 100) < 6;
            redirect_pc = $urandom;
            #1;
            if (imem_req) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_left   = $urandom % 4;
                    m_addr   = imem_addr;
                end else begin
                    chk("rnd_addr_stable", imem_addr, m_addr);
                end
                if (m_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mw(m_addr);
                    m_active   = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = JUNK;
                    m_left--;
                end
            end else begin
                // Stray acks with no request must be ignored.
                imem_ack   = ($urandom % 4) == 0;
                imem_rdata = JUNK;
            end
            if (fetch_valid && !stall_if && !redirect) begin
                chk("rnd_pcout", PCOUT, exp_pc);
                chk("rnd_ir", IR, mw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_red  = redirect;
            prev_hold = fetch_valid & stall_if & ~redirect;
            hold_pc   = PCOUT;
            hold_ir   = IR;
        end
        chk("rnd_throughput", {31'b0, ncons > 200}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
